// File: rtl/uart_rx.sv
// 8N1 serial receiver: synchronises rx, detects the start edge, samples each bit mid-period
// and presents the received byte with a one-cycle valid strobe (or a frame_err strobe).
module uart_rx #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  output logic                 busy,
  output logic                 frame_err
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF     = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_IDX = 3'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t               state_r;
  logic [CW-1:0]        cnt_r;
  logic [2:0]           bit_idx_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 rx_s;
  logic                 rx_last_r;
  logic                 start_s;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign rx_s = rx;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_r;

      // rx synchroniser chain, reset to the idle-high line level
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          sync_r <= {SYNC_STAGES{1'b1}};
        end else begin
          sync_r[0] <= rx;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_r[i] <= sync_r[i-1];
          end
        end
      end

      assign rx_s = sync_r[SYNC_STAGES-1];
    end
  endgenerate

  // A held-low line cannot re-trigger: a start needs a 1->0 transition on rx_s.
  assign start_s = rx_last_r & ~rx_s;
  // The detection cycle already counts as busy, so busy spans detection through stop sample.
  assign busy    = (state_r != IDLE) | start_s;

  // Receive FSM with registered data_out/valid/frame_err
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cnt_r     <= {CW{1'b0}};
      bit_idx_r <= 3'd0;
      shift_r   <= {DATA_BITS{1'b0}};
      data_out  <= {DATA_BITS{1'b0}};
      valid     <= 1'b0;
      frame_err <= 1'b0;
      rx_last_r <= 1'b1;
    end else begin
      rx_last_r <= rx_s;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state_r)
        IDLE: begin
          cnt_r     <= {CW{1'b0}};
          bit_idx_r <= 3'd0;
          if (start_s) begin
            // At one clock per bit the detection cycle is the whole start bit.
            if (CLKS_PER_BIT == 1) begin
              state_r <= DATA;
            end else begin
              state_r <= START;
              cnt_r   <= CW'(1'b1);
            end
          end
        end
        START: begin
          if ((cnt_r == HALF) && rx_s) begin
            state_r <= IDLE;
            cnt_r   <= {CW{1'b0}};
          end else if (cnt_r == LAST) begin
            state_r   <= DATA;
            cnt_r     <= {CW{1'b0}};
            bit_idx_r <= 3'd0;
          end else begin
            cnt_r <= cnt_r + CW'(1'b1);
          end
        end
        DATA: begin
          if (cnt_r == HALF) begin
            shift_r[bit_idx_r] <= rx_s;
          end
          if (cnt_r == LAST) begin
            cnt_r <= {CW{1'b0}};
            if (bit_idx_r == LAST_IDX) begin
              state_r <= STOP;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
            end
          end else begin
            cnt_r <= cnt_r + CW'(1'b1);
          end
        end
        STOP: begin
          // Leave at the stop-bit sample so a back-to-back start is not missed.
          if (cnt_r == HALF) begin
            state_r <= IDLE;
            cnt_r   <= {CW{1'b0}};
            if (rx_s) begin
              data_out <= shift_r;
              valid    <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt_r <= cnt_r + CW'(1'b1);
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= {CW{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: one instance at 1 clk/bit and one at 16 clk/bit, with
// hand-computed frames, strobe counting monitors and a latency/spacing check.
module tb_uart_rx;

  logic       clk;
  logic       rst_n;
  logic       rx1;
  logic       rx16;
  logic [7:0] data1;
  logic [7:0] data16;
  logic       valid1, busy1, fe1;
  logic       valid16, busy16, fe16;

  int n_err    = 0;
  int n_checks = 0;
  int cyc      = 0;
  int stop_cyc = 0;

  logic [7:0] v1_q[$];
  int         v1_cyc[$];
  logic [7:0] v16_q[$];
  int         fe1_n, busy1_n, fe16_n, busy16_n;

  uart_rx #(.DATA_BITS(8), .CLKS_PER_BIT(1), .SYNC_STAGES(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .rx(rx1),
    .data_out(data1), .valid(valid1), .busy(busy1), .frame_err(fe1)
  );

  uart_rx #(.DATA_BITS(8), .CLKS_PER_BIT(16), .SYNC_STAGES(2)) dut16 (
    .clk(clk), .rst_n(rst_n), .rx(rx16),
    .data_out(data16), .valid(valid16), .busy(busy16), .frame_err(fe16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe/busy monitors sampled mid-cycle
  always @(negedge clk) begin
    if (valid1) begin
      v1_q.push_back(data1);
      v1_cyc.push_back(cyc);
    end
    if (valid16) v16_q.push_back(data16);
    if (fe1)     fe1_n++;
    if (fe16)    fe16_n++;
    if (busy1)   busy1_n++;
    if (busy16)  busy16_n++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] qdata1(input int idx);
    if (idx < v1_q.size()) return {24'd0, v1_q[idx]};
    return 32'hDEAD;
  endfunction

  function automatic int qcyc1(input int idx);
    if (idx < v1_cyc.size()) return v1_cyc[idx];
    return -1000;
  endfunction

  task automatic clear_mon();
    v1_q.delete();
    v1_cyc.delete();
    v16_q.delete();
    fe1_n    = 0;
    fe16_n   = 0;
    busy1_n  = 0;
    busy16_n = 0;
  endtask

  task automatic drive(input bit sel, input logic b);
    if (sel) rx16 = b;
    else     rx1  = b;
  endtask

  task automatic hold(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives a full frame, start bit first; the line is left at the stop-bit level.
  task automatic send_frame(input logic [7:0] d, input logic stop, input bit sel, input int cpb);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      drive(sel, bits[i]);
      if (i == 9) stop_cyc = cyc;
      hold(cpb);
    end
  endtask

  task automatic idle(input bit sel, input logic level, input int n);
    drive(sel, level);
    hold(n);
  endtask

  // Bench-side stand-in for uart_tx: a 10-bit shift register shifting out LSB first.
  task automatic tx_model(input logic [7:0] d);
    logic [9:0] sr;
    sr = {1'b1, d, 1'b0};
    repeat (10) begin
      rx1 = sr[0];
      sr  = {1'b1, sr[9:1]};
      hold(1);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    rx1   = 1'b1;
    rx16  = 1'b1;
    clear_mon();
    hold(3);
    check("rst_data",  {24'd0, data1}, 32'h00);
    check("rst_valid", {31'd0, valid1}, 32'd0);
    check("rst_busy",  {31'd0, busy1}, 32'd0);
    check("rst_ferr",  {31'd0, fe1}, 32'd0);
    check("rst_data16", {24'd0, data16}, 32'h00);
    rst_n = 1'b1;
    hold(4);

    // 1: single 0xA5 frame
    clear_mon();
    send_frame(8'hA5, 1'b1, 1'b0, 1);
    idle(1'b0, 1'b1, 6);
    check("t1_count",   v1_q.size(), 32'd1);
    check("t1_data",    qdata1(0), 32'hA5);
    check("t1_ferr",    fe1_n, 32'd0);
    check("t1_busy",    busy1_n, 32'd10);
    check("t1_latency", qcyc1(0), stop_cyc + 3);

    // 2: back-to-back 0xA5, 0x3C
    clear_mon();
    send_frame(8'hA5, 1'b1, 1'b0, 1);
    send_frame(8'h3C, 1'b1, 1'b0, 1);
    idle(1'b0, 1'b1, 6);
    check("t2_count",   v1_q.size(), 32'd2);
    check("t2_data0",   qdata1(0), 32'hA5);
    check("t2_data1",   qdata1(1), 32'h3C);
    check("t2_spacing", qcyc1(1) - qcyc1(0), 32'd10);
    check("t2_ferr",    fe1_n, 32'd0);

    // 3: bad stop bit, then line held low
    clear_mon();
    send_frame(8'h5A, 1'b0, 1'b0, 1);
    idle(1'b0, 1'b0, 20);
    check("t3_ferr",     fe1_n, 32'd1);
    check("t3_valid",    v1_q.size(), 32'd0);
    check("t3_data",     {24'd0, data1}, 32'h3C);
    check("t3_busy_cnt", busy1_n, 32'd10);
    check("t3_busy_now", {31'd0, busy1}, 32'd0);
    idle(1'b0, 1'b1, 5);

    // 4: glitches at 16 clk/bit are false starts, then a real 0xC3 frame
    clear_mon();
    idle(1'b1, 1'b0, 1);
    idle(1'b1, 1'b1, 40);
    check("t4_g1_busy", busy16_n, 32'd8);
    busy16_n = 0;
    idle(1'b1, 1'b0, 7);
    idle(1'b1, 1'b1, 40);
    check("t4_g7_busy",  busy16_n, 32'd8);
    check("t4_g_valid",  v16_q.size(), 32'd0);
    check("t4_g_ferr",   fe16_n, 32'd0);
    send_frame(8'hC3, 1'b1, 1'b1, 16);
    idle(1'b1, 1'b1, 20);
    check("t4_count", v16_q.size(), 32'd1);
    check("t4_data",  (v16_q.size() > 0) ? {24'd0, v16_q[0]} : 32'hDEAD, 32'hC3);
    check("t4_ferr",  fe16_n, 32'd0);

    // 5: reset during bit 4 of a frame
    clear_mon();
    begin
      logic [5:0] part;
      part = {8'h81, 1'b0} & 6'h3F;
      for (int i = 0; i < 5; i++) begin
        rx1 = part[i];
        hold(1);
      end
    end
    rx1   = 1'b0;
    rst_n = 1'b0;
    rx1   = 1'b1;
    hold(3);
    rst_n = 1'b1;
    hold(3);
    check("t5_data",  {24'd0, data1}, 32'h00);
    check("t5_busy",  {31'd0, busy1}, 32'd0);
    check("t5_valid", v1_q.size(), 32'd0);
    check("t5_ferr",  fe1_n, 32'd0);
    send_frame(8'h81, 1'b1, 1'b0, 1);
    idle(1'b0, 1'b1, 6);
    check("t5_count", v1_q.size(), 32'd1);
    check("t5_rx81",  qdata1(0), 32'h81);

    // 6: loopback through the serialiser model
    clear_mon();
    tx_model(8'hA5);
    tx_model(8'h3C);
    idle(1'b0, 1'b1, 6);
    check("t6_data0", qdata1(0), 32'hA5);
    check("t6_data1", qdata1(1), 32'h3C);
    check("t6_ferr",  fe1_n, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
